// File: rtl/fsm.sv
// Two-direction (north/west) traffic-light controller with registered light code.
// Optional macro FSM_ALT_PRIORITY_EN: alternating tie-break instead of fixed north priority.
module fsm #(
   parameter int unsigned GREEN_CYCLES  = 2,
   parameter int unsigned YELLOW_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       n,
   input  logic       w,
   output logic [1:0] light
);

   localparam int unsigned MAX_CYCLES = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
   localparam logic [CW-1:0] G_LAST   = CW'(GREEN_CYCLES - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW_CYCLES - 1);

   localparam logic [1:0] L_RED    = 2'b00;
   localparam logic [1:0] L_NORTH  = 2'b01;
   localparam logic [1:0] L_WEST   = 2'b10;
   localparam logic [1:0] L_YELLOW = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GREEN_N = 2'b01,
      GREEN_W = 2'b10,
      YELLOW  = 2'b11
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          dir, dir_nx;        // phase owner: 0 north, 1 west
   logic [1:0]    light_nx;
   logic          north_wins;
   logic          start_n, start_w;

`ifdef FSM_ALT_PRIORITY_EN
   logic          last_west, last_west_nx;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         dir   <= 1'b0;
         light <= L_RED;
`ifdef FSM_ALT_PRIORITY_EN
         last_west <= 1'b1;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         dir   <= dir_nx;
         light <= light_nx;
`ifdef FSM_ALT_PRIORITY_EN
         last_west <= last_west_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt + 1'b1;
      dir_nx     = dir;
      light_nx   = L_RED;
`ifdef FSM_ALT_PRIORITY_EN
      last_west_nx = last_west;
      north_wins   = last_west;
`else
      north_wins   = 1'b1;
`endif
      start_n = n & (~w | north_wins);
      start_w = w & ~start_n;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (start_n) begin
               state_nx = GREEN_N;
               dir_nx   = 1'b0;
`ifdef FSM_ALT_PRIORITY_EN
               last_west_nx = 1'b0;
`endif
            end else if (start_w) begin
               state_nx = GREEN_W;
               dir_nx   = 1'b1;
`ifdef FSM_ALT_PRIORITY_EN
               last_west_nx = 1'b1;
`endif
            end
         end
         GREEN_N, GREEN_W: begin
            if (cnt == G_LAST) begin
               state_nx = YELLOW;
               cnt_nx   = '0;
            end
         end
         YELLOW: begin
            if (cnt == Y_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               dir_nx   = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            dir_nx   = 1'b0;
         end
      endcase

      // Light is registered from the next state so it changes on the same edge as the state.
      case (state_nx)
         GREEN_N: light_nx = L_NORTH;
         GREEN_W: light_nx = L_WEST;
         YELLOW:  light_nx = L_YELLOW;
         default: light_nx = L_RED;
      endcase
   end

endmodule

// File: tb/tb_fsm.sv
// Directed scoreboard bench for the traffic-light controller fsm.
module tb_fsm;

   logic       clk;
   logic       reset;
   logic       n;
   logic       w;
   logic [1:0] light;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [1:0]  exp_q[$];

   fsm #(.GREEN_CYCLES(2), .YELLOW_CYCLES(1)) dut (
      .clk   (clk),
      .reset (reset),
      .n     (n),
      .w     (w),
      .light (light)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag);
      logic [1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s observed=%b expected=<empty scoreboard>", tag, light);
      end else begin
         e = exp_q.pop_front();
         assert (light === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, light, e);
         end
      end
   endtask

   // Called at a negedge: drive inputs, expect light after the next rising edge.
   task automatic cycle(input logic nn, input logic ww, input logic [1:0] e, input string tag);
      n = nn;
      w = ww;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check(tag);
   endtask

`ifdef FSM_ALT_PRIORITY_EN
   localparam logic [1:0] TIE_AFTER_NORTH = 2'b10;
`else
   localparam logic [1:0] TIE_AFTER_NORTH = 2'b01;
`endif

   initial begin
      reset = 1'b1;
      n = 1'b0;
      w = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(2'b00);
      check("reset_held");
      reset = 1'b0;
      cycle(0, 0, 2'b00, "idle_after_reset_0");
      cycle(0, 0, 2'b00, "idle_after_reset_1");

      // north pulse
      cycle(1, 0, 2'b01, "north_g0");
      cycle(0, 0, 2'b01, "north_g1");
      cycle(0, 0, 2'b11, "north_y");
      cycle(0, 0, 2'b00, "north_idle0");
      cycle(0, 0, 2'b00, "north_idle1");

      // north, then west request during green is dropped
      cycle(1, 0, 2'b01, "nw_g0");
      cycle(0, 1, 2'b01, "nw_g1_wreq");
      cycle(0, 0, 2'b11, "nw_y");
      cycle(0, 0, 2'b00, "nw_idle0");
      cycle(0, 0, 2'b00, "nw_idle1");

      // west pulse, then north request ignored
      cycle(0, 1, 2'b10, "west_g0");
      cycle(1, 0, 2'b10, "west_g1_nreq");
      cycle(0, 0, 2'b11, "west_y");
      cycle(0, 0, 2'b00, "west_idle0");
      cycle(0, 0, 2'b00, "west_idle1");

      // north phase, then tie
      cycle(1, 0, 2'b01, "pre_tie_g0");
      cycle(0, 0, 2'b01, "pre_tie_g1");
      cycle(0, 0, 2'b11, "pre_tie_y");
      cycle(0, 0, 2'b00, "pre_tie_idle");
      cycle(1, 1, TIE_AFTER_NORTH, "tie_g0");
      cycle(0, 0, TIE_AFTER_NORTH, "tie_g1");
      cycle(0, 0, 2'b11, "tie_y");
      cycle(0, 0, 2'b00, "tie_idle");

      // held request restarts only after returning to idle
      cycle(1, 0, 2'b01, "hold_g0");
      cycle(1, 0, 2'b01, "hold_g1");
      cycle(1, 0, 2'b11, "hold_y");
      cycle(1, 0, 2'b00, "hold_idle");
      cycle(1, 0, 2'b01, "hold_restart_g0");
      cycle(0, 0, 2'b01, "hold_restart_g1");
      cycle(0, 0, 2'b11, "hold_restart_y");
      cycle(0, 0, 2'b00, "hold_restart_idle");

      // asynchronous reset mid-green
      cycle(1, 0, 2'b01, "midrst_g0");
      n = 1'b0;
      reset = 1'b1;
      #1;
      exp_q.push_back(2'b00);
      check("async_reset_no_edge");
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(2'b00);
      check("async_reset_held");
      reset = 1'b0;
      cycle(0, 0, 2'b00, "post_rst_idle");
      cycle(1, 0, 2'b01, "post_rst_g0");
      cycle(0, 0, 2'b01, "post_rst_g1");
      cycle(0, 0, 2'b11, "post_rst_y");
      cycle(0, 0, 2'b00, "post_rst_idle2");

      // tie right after reset goes north in both builds (reset last-served is west,
      // and the north phase above set it to north in the alternating build)
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cycle(1, 1, 2'b01, "rst_tie_g0");
      cycle(0, 0, 2'b01, "rst_tie_g1");
      cycle(0, 0, 2'b11, "rst_tie_y");
      cycle(0, 0, 2'b00, "rst_tie_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fsm.md
Name: fsm

Overview:
- Two-direction traffic-light controller for a north/west intersection.
- Single-cycle request pulses on n (north) or w (west) start one green phase for that direction, followed by a yellow phase, then a return to all-red idle.
- Self-contained control block; the light code drives the lamp decoder.

Parameters:
- GREEN_CYCLES, 2, clock cycles light holds green per phase (legal >=1)
- YELLOW_CYCLES, 1, clock cycles light holds yellow per phase (legal >=1)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset; clears state and light immediately
- n  input  1  north request, sampled on rising clk
- w  input  1  west request, sampled on rising clk
- light  output  2  registered light code: 2'b00 all red, 2'b01 north green, 2'b10 west green, 2'b11 yellow (active direction)

Interface decision: one clock (clk); reset is asynchronous and active-high (reset).

Behaviour:
- States: IDLE, GREEN_N, GREEN_W, YELLOW. A direction register records the phase owner while in YELLOW. A phase counter is sized by $clog2 of the larger of the two parameters, plus 1.
- reset asserted (any time, including mid-phase): state=IDLE, light=2'b00, counter=0, direction cleared; takes effect without a clock edge.
- First rising edge after reset deasserts: normal sampling begins.
- IDLE:
  - light=00.
  - On an edge with n=1, w=0 -> GREEN_N.
  - On an edge with w=1, n=0 -> GREEN_W.
  - Both 0 -> stay in IDLE.
- Simultaneous n=1, w=1 in IDLE: north wins (GREEN_N), unless the optional feature is enabled.
- Latency: request sampled at edge k -> light shows green from edge k (registered output valid in the cycle after edge k).
- GREEN_N / GREEN_W:
  - light=01 / 10 for exactly GREEN_CYCLES cycles, then YELLOW.
- YELLOW:
  - light=11 for exactly YELLOW_CYCLES cycles, then IDLE (light=00).
- Requests on n or w in any non-IDLE state are ignored and not queued. This includes a request for the other direction and a repeat request for the current direction.
- A request held high continuously restarts a new phase on the first edge after the controller returns to IDLE.
- Total busy time per phase: GREEN_CYCLES+YELLOW_CYCLES cycles. With defaults, 3 cycles; IDLE is reached at edge k+3.
- light is always one of the four legal codes. There is no state in which both directions are green.
- Illegal or unreachable state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: FSM_ALT_PRIORITY_EN.
- Defined:
  - A 1-bit last-served register (reset value: west) arbitrates simultaneous n=1, w=1 requests in IDLE.
  - The direction not served last wins. The first tie after reset goes to north, the next tie to west, and so on.
  - The register updates on every phase start, single requests included.
- Not defined:
  - Fixed north priority.
  - The last-served register is not instantiated.

Test Plan:
- Reset: hold reset=1 for 1 cycle, release mid-cycle -> light=00 during and after reset; deassert n/w -> stays 00.
- North pulse: n=1 for one edge k -> light=01 for 2 cycles, 11 for 1 cycle, then 00 from edge k+3 on.
- North then west attempt: n=1 at edge k, w=1 at edge k+1 -> north phase exactly as above; no west green follows; light 00 after edge k+3.
- West pulse after idle: w=1 at edge k -> light=10 for 2 cycles, 11 for 1, then 00. Then n=1 at k+1 -> ignored.
- Simultaneous n=w=1 one edge -> light=01, 01, 11, 00 (north priority). With FSM_ALT_PRIORITY_EN, after a prior north phase, the same tie gives 10, 10, 11, 00.
- Reset mid-phase: assert reset during green -> light=00 immediately, no clock needed. After release, state is IDLE and n=1 starts a fresh 2+1 cycle phase.
